reg_scoreboard: RTL and testbench

//  ID-stage register scoreboard. Tracks in-flight register-file writes that cannot be forwarded yet.

---
 rtl/reg_scoreboard.sv | 125 ++++++++++++
 tb/tb_reg_scoreboard.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: ID-stage register scoreboard for in-flight load and mult/div writes.
// Latency: stall_o is combinational from registered state; entries update on the next clock.
// Backpressure: stall_o holds ID; pipe_stall freezes issue and load countdowns.
// Optional build macro REG_SB_STATS_EN adds stat_raw/stat_waw/stat_str stall-cause counters.
module reg_scoreboard #(
  parameter int LOAD_LAT = 1,  // 1..3
  parameter int MAX_LONG = 2   // 1..7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        pipe_stall,
  input  logic        flush,
  input  logic        rd_en_1,
  input  logic        rd_en_2,
  input  logic [4:0]  rd_addr_1,
  input  logic [4:0]  rd_addr_2,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic        is_load,
  input  logic        is_long,
  input  logic        lg_done,
  input  logic [4:0]  lg_done_addr,
  output logic        stall_o,
  output logic [31:0] pend_mask,
  output logic [2:0]  long_cnt
`ifdef REG_SB_STATS_EN
  ,
  output logic [31:0] stat_raw,
  output logic [31:0] stat_waw,
  output logic [31:0] stat_str
`endif
);

  localparam logic [1:0] LOAD_LAT_C = 2'(LOAD_LAT);
  localparam logic [2:0] MAX_LONG_C = 3'(MAX_LONG);

  logic [1:0]  lcnt_q [32];
  logic [1:0]  lcnt_d [32];
  logic [31:0] lpend_q, lpend_d;
  logic [2:0]  long_cnt_q, long_cnt_d;

  logic [31:0] pend;
  logic        raw, waw, str, issue, wr_ok, done_hit, long_inc, long_dec;

  // Pending view per GPR; $0 is never pending.
  always_comb begin
    pend = '0;
    for (int r = 1; r < 32; r++) begin
      pend[r] = (lcnt_q[r] != 2'd0) | lpend_q[r];
    end
  end

  assign raw      = (rd_en_1 & (rd_addr_1 != 5'd0) & pend[rd_addr_1]) |
                    (rd_en_2 & (rd_addr_2 != 5'd0) & pend[rd_addr_2]);
  assign waw      = wr_en & (wr_addr != 5'd0) & lpend_q[wr_addr];
  assign str      = is_long & (long_cnt_q == MAX_LONG_C);
  assign stall_o  = id_valid & (raw | waw | str);
  assign issue    = id_valid & ~stall_o & ~pipe_stall & ~flush;
  assign wr_ok    = wr_en & (wr_addr != 5'd0);
  // A completion for a GPR with no long entry is stale and must not touch the count.
  assign done_hit = lg_done & lpend_q[lg_done_addr];
  assign long_inc = issue & wr_ok & is_long & (long_cnt_q != MAX_LONG_C);
  assign long_dec = done_hit & (long_cnt_q != 3'd0);

  assign pend_mask = pend;
  assign long_cnt  = long_cnt_q;

  // Next state: countdown/complete first, then issue overrides so a re-armed entry wins.
  always_comb begin
    lpend_d    = lpend_q;
    long_cnt_d = long_cnt_q;
    for (int r = 0; r < 32; r++) begin
      lcnt_d[r] = (~pipe_stall && lcnt_q[r] != 2'd0) ? lcnt_q[r] - 2'd1 : lcnt_q[r];
    end
    if (done_hit) lpend_d[lg_done_addr] = 1'b0;
    if (issue && wr_ok && is_load) lcnt_d[wr_addr] = LOAD_LAT_C;
    if (issue && wr_ok && is_long) lpend_d[wr_addr] = 1'b1;
    case ({long_inc, long_dec})
      2'b10:   long_cnt_d = long_cnt_q + 3'd1;
      2'b01:   long_cnt_d = long_cnt_q - 3'd1;
      default: long_cnt_d = long_cnt_q;
    endcase
    if (flush) begin
      for (int r = 0; r < 32; r++) lcnt_d[r] = 2'd0;
      lpend_d    = '0;
      long_cnt_d = 3'd0;
    end
  end

  // Scoreboard state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) lcnt_q[r] <= 2'd0;
      lpend_q    <= '0;
      long_cnt_q <= 3'd0;
    end else begin
      for (int r = 0; r < 32; r++) lcnt_q[r] <= lcnt_d[r];
      lpend_q    <= lpend_d;
      long_cnt_q <= long_cnt_d;
    end
  end

`ifdef REG_SB_STATS_EN
  logic [31:0] stat_raw_q, stat_waw_q, stat_str_q;

  // Saturating stall-cause counters; flush deliberately leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_raw_q <= '0;
      stat_waw_q <= '0;
      stat_str_q <= '0;
    end else begin
      if (stall_o && raw && stat_raw_q != 32'hFFFF_FFFF) stat_raw_q <= stat_raw_q + 32'd1;
      if (stall_o && waw && stat_waw_q != 32'hFFFF_FFFF) stat_waw_q <= stat_waw_q + 32'd1;
      if (stall_o && str && stat_str_q != 32'hFFFF_FFFF) stat_str_q <= stat_str_q + 32'd1;
    end
  end

  assign stat_raw = stat_raw_q;
  assign stat_waw = stat_waw_q;
  assign stat_str = stat_str_q;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed hazard scenarios followed by random traffic,
// every cycle compared against a reference model built from per-register
// remaining-latency counts and a queue of outstanding long destinations.
module tb_reg_scoreboard;
  localparam int LL = 1;
  localparam int ML = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, id_valid, pipe_stall, flush;
  logic        rd_en_1, rd_en_2, wr_en, is_load, is_long, lg_done;
  logic [4:0]  rd_addr_1, rd_addr_2, wr_addr, lg_done_addr;
  logic        stall_o;
  logic [31:0] pend_mask;
  logic [2:0]  long_cnt;
`ifdef REG_SB_STATS_EN
  logic [31:0] stat_raw, stat_waw, stat_str;
`endif

  reg_scoreboard #(.LOAD_LAT(LL), .MAX_LONG(ML)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .pipe_stall(pipe_stall), .flush(flush),
    .rd_en_1(rd_en_1), .rd_en_2(rd_en_2), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .wr_en(wr_en), .wr_addr(wr_addr), .is_load(is_load), .is_long(is_long),
    .lg_done(lg_done), .lg_done_addr(lg_done_addr),
    .stall_o(stall_o), .pend_mask(pend_mask), .long_cnt(long_cnt)
`ifdef REG_SB_STATS_EN
    , .stat_raw(stat_raw), .stat_waw(stat_waw), .stat_str(stat_str)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: cycles left before each load result is forwardable,
  // and the set of GPRs awaiting a long-unit completion.
  int lrem [32];
  int lq [$];
  logic [31:0] m_sraw, m_swaw, m_sstr;

  function automatic bit in_long(input int a);
    for (int i = 0; i < lq.size(); i++) if (lq[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_pend(input int a);
    return (a != 0) && (lrem[a] > 0 || in_long(a));
  endfunction

  function automatic bit m_raw_c();
    return (rd_en_1 && is_pend(int'(rd_addr_1))) || (rd_en_2 && is_pend(int'(rd_addr_2)));
  endfunction

  function automatic bit m_waw_c();
    return wr_en && wr_addr != 5'd0 && in_long(int'(wr_addr));
  endfunction

  function automatic bit m_str_c();
    return is_long && lq.size() == ML;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m;
    m = '0;
    for (int r = 1; r < 32; r++) m[r] = is_pend(r);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) lrem[r] = 0;
    lq.delete();
  endtask

  // Compare this cycle's outputs, clock once, then advance the model with the same inputs.
  task automatic cyc();
    bit st, r, w, s, iss;
    #2;
    r  = m_raw_c();
    w  = m_waw_c();
    s  = m_str_c();
    st = id_valid && (r || w || s);
    chk("stall", {31'd0, stall_o}, {31'd0, st});
    chk("pend_mask", pend_mask, m_mask());
    chk("long_cnt", {29'd0, long_cnt}, 32'(lq.size()));
`ifdef REG_SB_STATS_EN
    chk("stat_raw", stat_raw, m_sraw);
    chk("stat_waw", stat_waw, m_swaw);
    chk("stat_str", stat_str, m_sstr);
`endif
    @(posedge clk);
    if (rst) begin
      model_clear();
      m_sraw = '0; m_swaw = '0; m_sstr = '0;
    end else begin
      if (st && r && m_sraw != 32'hFFFF_FFFF) m_sraw++;
      if (st && w && m_swaw != 32'hFFFF_FFFF) m_swaw++;
      if (st && s && m_sstr != 32'hFFFF_FFFF) m_sstr++;
      if (flush) begin
        model_clear();
      end else begin
        iss = id_valid && !st && !pipe_stall;
        if (!pipe_stall) for (int i = 0; i < 32; i++) if (lrem[i] > 0) lrem[i]--;
        if (lg_done) begin
          for (int i = 0; i < lq.size(); i++) begin
            if (lq[i] == int'(lg_done_addr)) begin
              lq.delete(i);
              break;
            end
          end
        end
        if (iss && wr_en && wr_addr != 5'd0) begin
          if (is_load) lrem[wr_addr] = LL;
          if (is_long && !in_long(int'(wr_addr))) lq.push_back(int'(wr_addr));
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    id_valid = 0; pipe_stall = 0; flush = 0; rd_en_1 = 0; rd_en_2 = 0;
    rd_addr_1 = 0; rd_addr_2 = 0; wr_en = 0; wr_addr = 0; is_load = 0; is_long = 0;
    lg_done = 0; lg_done_addr = 0;
  endtask

  task automatic ins(input logic r1e, input logic [4:0] r1, input logic r2e, input logic [4:0] r2,
                     input logic we, input logic [4:0] wa, input logic ld, input logic lg);
    id_valid = 1; rd_en_1 = r1e; rd_addr_1 = r1; rd_en_2 = r2e; rd_addr_2 = r2;
    wr_en = we; wr_addr = wa; is_load = ld; is_long = lg;
  endtask

  initial begin
    model_clear();
    m_sraw = '0; m_swaw = '0; m_sstr = '0;
    idle();
    rst = 1;
    @(posedge clk); #1;
    cyc(); cyc();
    rst = 0;
    #1;
    chk("reset_stall", {31'd0, stall_o}, 32'd0);
    chk("reset_pend", pend_mask, 32'd0);
    chk("reset_long", {29'd0, long_cnt}, 32'd0);

    // Load-use: one stall cycle, then the dependent op issues.
    ins(0, 0, 0, 0, 1, 8, 1, 0); cyc();
    ins(1, 8, 0, 0, 0, 0, 0, 0);
    #1 chk("t1_stall", {31'd0, stall_o}, 32'd1);
    chk("t1_pend8", {31'd0, pend_mask[8]}, 32'd1);
    cyc();
    #1 chk("t1_release", {31'd0, stall_o}, 32'd0);
    chk("t1_pend8_clr", {31'd0, pend_mask[8]}, 32'd0);
    cyc();

    // Long RAW: held until the cycle after lg_done.
    ins(0, 0, 0, 0, 1, 9, 0, 1); cyc();
    ins(1, 9, 0, 0, 0, 0, 0, 0);
    #1 chk("t2_stall", {31'd0, stall_o}, 32'd1);
    chk("t2_long1", {29'd0, long_cnt}, 32'd1);
    cyc(); cyc();
    lg_done = 1; lg_done_addr = 9;
    #1 chk("t2_no_bypass", {31'd0, stall_o}, 32'd1);
    cyc();
    lg_done = 0;
    #1 chk("t2_release", {31'd0, stall_o}, 32'd0);
    chk("t2_long0", {29'd0, long_cnt}, 32'd0);
    cyc();

    // Structural: third long op waits for a slot.
    ins(0, 0, 0, 0, 1, 10, 0, 1); cyc();
    ins(0, 0, 0, 0, 1, 11, 0, 1); cyc();
    ins(0, 0, 0, 0, 1, 12, 0, 1);
    #1 chk("t3_stall", {31'd0, stall_o}, 32'd1);
    chk("t3_full", {29'd0, long_cnt}, 32'd2);
    cyc();
    lg_done = 1; lg_done_addr = 10; cyc();
    lg_done = 0;
    #1 chk("t3_issue", {31'd0, stall_o}, 32'd0);
    cyc();
    idle();
    #1 chk("t3_long2", {29'd0, long_cnt}, 32'd2);
    lg_done = 1; lg_done_addr = 11; cyc();
    lg_done_addr = 12; cyc();
    lg_done = 0;
    #1 chk("t3_drained", {29'd0, long_cnt}, 32'd0);
    cyc();

    // WAW against a long op; $0 never stalls and never allocates.
    ins(0, 0, 0, 0, 1, 5, 0, 1); cyc();
    ins(0, 0, 0, 0, 1, 5, 0, 0);
    #1 chk("t4_waw", {31'd0, stall_o}, 32'd1);
    cyc();
    ins(1, 0, 1, 0, 1, 0, 0, 1);
    #1 chk("t4_zero", {31'd0, stall_o}, 32'd0);
    cyc();
    idle();
    #1 chk("t4_no_alloc", {29'd0, long_cnt}, 32'd1);
    lg_done = 1; lg_done_addr = 5; cyc();
    idle(); cyc();

    // pipe_stall freezes the load countdown.
    ins(0, 0, 0, 0, 1, 4, 1, 0); cyc();
    idle(); pipe_stall = 1;
    repeat (3) begin
      #1 chk("t5_frozen", {31'd0, pend_mask[4]}, 32'd1);
      cyc();
    end
    pipe_stall = 0;
    #1 chk("t5_last", {31'd0, pend_mask[4]}, 32'd1);
    cyc();
    #1 chk("t5_clear", {31'd0, pend_mask[4]}, 32'd0);
    cyc();

    // Flush wipes two long and one load entry in one cycle.
    ins(0, 0, 0, 0, 1, 20, 0, 1); cyc();
    ins(0, 0, 0, 0, 1, 21, 0, 1); cyc();
    ins(0, 0, 0, 0, 1, 22, 1, 0); cyc();
    ins(1, 20, 0, 0, 0, 0, 0, 0); flush = 1;
    #1 chk("t6_pre", pend_mask, 32'h0070_0000);
    cyc();
    flush = 0;
    #1 chk("t6_pend0", pend_mask, 32'd0);
    chk("t6_long0", {29'd0, long_cnt}, 32'd0);
    chk("t6_stall0", {31'd0, stall_o}, 32'd0);
    cyc();

    // Random traffic on a small register window to keep hazards frequent.
    for (int n = 0; n < 3000; n++) begin
      int kind;
      rst        = ($urandom_range(0, 299) == 0);
      flush      = ($urandom_range(0, 39) == 0);
      pipe_stall = ($urandom_range(0, 4) == 0);
      id_valid   = ($urandom_range(0, 3) != 0);
      rd_en_1    = 1'($urandom_range(0, 1));
      rd_en_2    = 1'($urandom_range(0, 1));
      rd_addr_1  = 5'($urandom_range(0, 7));
      rd_addr_2  = 5'($urandom_range(0, 7));
      wr_en      = ($urandom_range(0, 3) != 0);
      wr_addr    = 5'($urandom_range(0, 7));
      kind       = int'($urandom_range(0, 4));
      is_load    = (kind == 1 || kind == 4);
      is_long    = (kind == 2 || kind == 4);
      lg_done    = ($urandom_range(0, 3) == 0);
      if (lq.size() > 0 && $urandom_range(0, 3) != 0)
        lg_done_addr = 5'(lq[$urandom_range(0, lq.size() - 1)]);
      else
        lg_done_addr = 5'($urandom_range(0, 7));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
